wb_bus_arbiter: RTL and testbench
=================================

// Module: wb_bus_arbiter
//
// PURPOSE
// Two-master, three-slave Wishbone classic interconnect for the picorv32_wb system.
// - Round-robin arbitration between master 0 (CPU) and master 1 (DMA/debug port).
// - Decodes the granted address to one of three slaves: RAM, GPIO1 or GPIO2.
// - Routes data and ack back to the granted master; replaces the ad-hoc enable_ram mux.
// - Answers unmapped addresses (and, optionally, hung slaves) with an error.
//
// PARAMETERS
// RAM_BYTES       128*1024        RAM window 0x0000_0000..RAM_BYTES-1; also 0x1000_0000/0x2000_0000 sim hooks
// GPIO1_BASE      32'h3000_0000   GPIO1 base; window = GPIO_WORDS words
// GPIO2_BASE      32'h4000_0000   GPIO2 base; window = GPIO_WORDS words
// GPIO_WORDS      3               words per GPIO window (extra_IO_addresses+1)
// TIMEOUT_CYCLES  255             stb-without-ack cycles before error (WB_TIMEOUT_EN only)
//
// PORTS
// wb_clk_i    in   1   clock, all state on rising edge
// wb_rst_i    in   1   synchronous reset, active-high
// m0_adr_i/m1_adr_i  in  32  master byte address
// m0_dat_i/m1_dat_i  in  32  master write data
// m0_sel_i/m1_sel_i  in  4   byte selects
// m0_we_i/m1_we_i    in  1   write enable
// m0_cyc_i/m1_cyc_i  in  1   bus request; held high = bus locked
// m0_stb_i/m1_stb_i  in  1   transfer strobe
// m0_dat_o/m1_dat_o  out 32  read data from selected slave
// m0_ack_o/m1_ack_o  out 1   transfer acknowledge
// m0_err_o/m1_err_o  out 1   transfer error (unmapped or timeout)
// s_adr_o     out  32  shared slave address (granted master)
// s_dat_o     out  32  shared write data
// s_sel_o     out  4   shared byte selects
// s_we_o      out  1   shared write enable
// s_stb_o     out  1   shared strobe
// s_cyc_o     out  3   one-hot cyc: [0] RAM, [1] GPIO1, [2] GPIO2
// s_dat_i     in   96  slave read data, {gpio2,gpio1,ram}
// s_ack_i     in   3   slave acks, same order
// grant_o     out  2   one-hot current grant, 00 = idle
//
// BEHAVIOUR
// - FSM: IDLE, GRANTED. IDLE->GRANTED when any cyc_i is high; GRANTED->IDLE the cycle after the owner drops cyc.
// - Arbitration happens only in IDLE. If both masters request, the master not granted last wins.
//   last_grant resets to 1, so m0 wins the first contention.
// - Grant is registered: the first slave cyc/stb appears 1 cycle after master cyc/stb rises in IDLE.
// - No re-arbitration while the owner holds cyc, including across back-to-back stb.
// - Decode is combinational on the granted adr. Hit only if (adr-BASE)>>2 < GPIO_WORDS (unsigned).
//   RAM hit: adr < RAM_BYTES, or adr == 0x1000_0000, or adr == 0x2000_0000.
// - s_cyc_o[k] = granted cyc & hit[k]. s_stb_o = granted stb. No slave is selected on a miss.
// - Routing is combinational: owner dat_o/ack_o = selected slave's dat/ack. The non-owner sees ack=err=0.
//   The non-owner's dat_o holds the same muxed value.
// - Miss: err_o is registered, pulses 1 cycle after stb, for exactly 1 cycle. The next cycle is ignored even if stb is still high.
// - ack and err are never high in the same cycle.
// - Reset: grant_o=00, all s_cyc_o=0, s_stb_o=0, ack/err=0, FSM=IDLE, last_grant=1, timeout counter=0.
// - Reset mid-transfer drops all cycles immediately. A late slave ack after reset is ignored.
// - Owner cyc dropping mid-transfer (no ack yet): slave cyc drops the same cycle and the transfer is abandoned.
//
// CONFIGURATION
// WB_TIMEOUT_EN defined:
// - 8-bit+ counter runs while s_stb_o is high and no ack/err; cleared on ack, err, stb low or grant change.
// - At TIMEOUT_CYCLES the owner gets a 1-cycle err_o and the counter clears.
// WB_TIMEOUT_EN undefined:
// - No counter; a transfer to a non-acking slave stalls forever.
//
// TESTING
// 1. m0 reads 0x0000_0010, RAM acks after 2 cycles -> s_cyc_o=001, m0_ack_o=1 with m0_dat_o=s_dat_i[31:0]; m1_ack_o=0.
// 2. m0 and m1 raise cyc together out of reset -> grant_o=01. m0 drops cyc, m1 still requests -> grant_o=00 for 1 cycle, then 10.
// 3. m1 writes 0x4000_0008 data 0xDEADBEEF -> s_cyc_o=100, s_dat_o=0xDEADBEEF, s_sel_o passes through, m1_ack_o follows s_ack_i[2].
// 4. m0 reads 0x3000_000C (word 3, out of window) -> s_cyc_o=000, m0_err_o pulses 1 cycle after stb, m0_ack_o stays 0.
// 5. WB_TIMEOUT_EN, TIMEOUT_CYCLES=8, RAM never acks -> m0_err_o high exactly 8 cycles after s_stb_o rose; without macro, no err in 1000 cycles.
// 6. wb_rst_i for 1 cycle while GPIO1 transfer pending -> next cycle s_cyc_o=000, grant_o=00; a subsequent s_ack_i[1] is not forwarded.

Source files
------------

// File: rtl/wb_bus_arbiter.sv
// Two-master / three-slave Wishbone classic interconnect with round-robin grant.
// Define WB_TIMEOUT_EN to answer hung slaves with an error after TIMEOUT_CYCLES.
module wb_bus_arbiter #(
  parameter int unsigned RAM_BYTES      = 128*1024,
  parameter logic [31:0] GPIO1_BASE     = 32'h3000_0000,
  parameter logic [31:0] GPIO2_BASE     = 32'h4000_0000,
  parameter int unsigned GPIO_WORDS     = 3,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic [31:0] m0_adr_i,
  input  logic [31:0] m0_dat_i,
  input  logic [3:0]  m0_sel_i,
  input  logic        m0_we_i,
  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  output logic [31:0] m0_dat_o,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  input  logic [31:0] m1_adr_i,
  input  logic [31:0] m1_dat_i,
  input  logic [3:0]  m1_sel_i,
  input  logic        m1_we_i,
  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  output logic [31:0] m1_dat_o,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  output logic [31:0] s_adr_o,
  output logic [31:0] s_dat_o,
  output logic [3:0]  s_sel_o,
  output logic        s_we_o,
  output logic        s_stb_o,
  output logic [2:0]  s_cyc_o,
  input  logic [95:0] s_dat_i,
  input  logic [2:0]  s_ack_i,
  output logic [1:0]  grant_o
);

  typedef enum logic {S_IDLE, S_GRANTED} state_t;

  state_t r_state, w_state_nxt;
  logic   r_owner, w_owner_nxt;
  logic   r_last, w_last_nxt;
  logic   r_err;

  logic        w_granted, w_cyc, w_stb, w_pick;
  logic [31:0] w_adr, w_off1, w_off2, w_dat;
  logic [2:0]  w_hit;
  logic        w_miss, w_ack, w_err, w_to;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state <= S_IDLE;
      r_owner <= 1'b0;
      r_last  <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_owner <= w_owner_nxt;
      r_last  <= w_last_nxt;
    end
  end

  // On contention the master that did not win last time gets the bus
  assign w_pick = (m0_cyc_i & m1_cyc_i) ? ~r_last : m1_cyc_i;

  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_last_nxt  = r_last;
    unique case (r_state)
      S_IDLE: begin
        if (m0_cyc_i | m1_cyc_i) begin
          w_state_nxt = S_GRANTED;
          w_owner_nxt = w_pick;
          w_last_nxt  = w_pick;
        end
      end
      S_GRANTED: begin
        if (!w_cyc) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_granted = (r_state == S_GRANTED);
  assign w_cyc = w_granted & (r_owner ? m1_cyc_i : m0_cyc_i);
  assign w_stb = w_cyc & (r_owner ? m1_stb_i : m0_stb_i);
  assign w_adr = r_owner ? m1_adr_i : m0_adr_i;

  assign s_adr_o = w_adr;
  assign s_dat_o = r_owner ? m1_dat_i : m0_dat_i;
  assign s_sel_o = r_owner ? m1_sel_i : m0_sel_i;
  assign s_we_o  = r_owner ? m1_we_i : m0_we_i;
  assign s_stb_o = w_stb;

  // Unsigned offsets: addresses below a base wrap high and miss
  assign w_off1   = w_adr - GPIO1_BASE;
  assign w_off2   = w_adr - GPIO2_BASE;
  assign w_hit[0] = (w_adr < 32'(RAM_BYTES))
                  | (w_adr == 32'h1000_0000)
                  | (w_adr == 32'h2000_0000);
  assign w_hit[1] = (w_off1 >> 2) < 32'(GPIO_WORDS);
  assign w_hit[2] = (w_off2 >> 2) < 32'(GPIO_WORDS);

  assign s_cyc_o = {3{w_cyc}} & w_hit;
  assign w_miss  = w_stb & ~|w_hit;
  assign w_ack   = |(s_ack_i & s_cyc_o);

  always_comb begin
    w_dat = 32'h0;
    unique case (1'b1)
      s_cyc_o[0]: w_dat = s_dat_i[31:0];
      s_cyc_o[1]: w_dat = s_dat_i[63:32];
      s_cyc_o[2]: w_dat = s_dat_i[95:64];
      default:    w_dat = 32'h0;
    endcase
  end

`ifdef WB_TIMEOUT_EN
  localparam int TW = ($clog2(TIMEOUT_CYCLES + 1) < 8) ?
                      8 : $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] r_cnt;

  assign w_to = w_stb & ~w_ack & ~r_err
              & (r_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_cnt <= '0;
    end else if (!w_stb || w_ack || r_err || w_to) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end
`else
  assign w_to = 1'b0;
`endif

  // A miss seen while an error is already showing is swallowed
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) r_err <= 1'b0;
    else          r_err <= (w_miss & ~r_err) | w_to;
  end

  assign w_err = r_err & ~w_ack & w_granted;

  always_comb begin
    grant_o  = w_granted ? (r_owner ? 2'b10 : 2'b01) : 2'b00;
    m0_dat_o = w_dat;
    m1_dat_o = w_dat;
    m0_ack_o = w_ack & ~r_owner;
    m1_ack_o = w_ack & r_owner;
    m0_err_o = w_err & ~r_owner;
    m1_err_o = w_err & r_owner;
  end

endmodule

// File: tb/tb_wb_bus_arbiter.sv
// Self-checking bench for wb_bus_arbiter: cycle model plus directed cases.
// Build with WB_TIMEOUT_EN to exercise the hung-slave timeout.
module tb_wb_bus_arbiter;

  localparam int unsigned RAM = 128*1024;
  localparam logic [31:0] G1 = 32'h3000_0000;
  localparam logic [31:0] G2 = 32'h4000_0000;
  localparam int unsigned GW = 3;
  localparam int unsigned TO = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [31:0] m0_adr, m0_dat, m1_adr, m1_dat;
  logic [3:0]  m0_sel, m1_sel;
  logic        m0_we, m0_cyc, m0_stb, m1_we, m1_cyc, m1_stb;
  logic [31:0] m0_dat_o, m1_dat_o;
  logic        m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
  logic [31:0] s_adr_o, s_dat_o;
  logic [3:0]  s_sel_o;
  logic        s_we_o, s_stb_o;
  logic [2:0]  s_cyc_o;
  logic [95:0] s_dat_i;
  logic [2:0]  s_ack_i;
  logic [1:0]  grant_o;

  wb_bus_arbiter #(
    .RAM_BYTES(RAM), .GPIO1_BASE(G1), .GPIO2_BASE(G2),
    .GPIO_WORDS(GW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .m0_adr_i(m0_adr), .m0_dat_i(m0_dat), .m0_sel_i(m0_sel),
    .m0_we_i(m0_we), .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb),
    .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
    .m1_adr_i(m1_adr), .m1_dat_i(m1_dat), .m1_sel_i(m1_sel),
    .m1_we_i(m1_we), .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb),
    .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o),
    .s_we_o(s_we_o), .s_stb_o(s_stb_o), .s_cyc_o(s_cyc_o),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .grant_o(grant_o)
  );

  int errors = 0;
  int checks = 0;
  bit en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // 0 = RAM, 1 = GPIO1, 2 = GPIO2, 3 = unmapped
  function automatic int region(input logic [31:0] a);
    if (a < RAM || a == 32'h1000_0000 || a == 32'h2000_0000) return 0;
    if (a >= G1 && a < G1 + 4 * GW) return 1;
    if (a >= G2 && a < G2 + 4 * GW) return 2;
    return 3;
  endfunction

  // Model: owner 0 idle / 1 m0 / 2 m1, last winner, error pending
  int m_own;
  bit m_last, m_err;
  int m_to;

  bit          e_gr, e_o, e_gcyc, e_gstb, e_ack, e_err, e_fire;
  int          e_reg;
  logic [31:0] e_adr, e_dat;
  logic [2:0]  e_scyc;
  logic [1:0]  e_grant;

  always_comb begin
    e_gr    = (m_own != 0);
    e_o     = (m_own == 2);
    e_gcyc  = e_gr && (e_o ? m1_cyc : m0_cyc);
    e_gstb  = e_gcyc && (e_o ? m1_stb : m0_stb);
    e_adr   = e_o ? m1_adr : m0_adr;
    e_reg   = region(e_adr);
    e_scyc  = 3'b000;
    e_dat   = 32'h0;
    e_ack   = 1'b0;
    if (e_gcyc) begin
      case (e_reg)
        0: begin e_scyc = 3'b001; e_dat = s_dat_i[31:0];  e_ack = s_ack_i[0]; end
        1: begin e_scyc = 3'b010; e_dat = s_dat_i[63:32]; e_ack = s_ack_i[1]; end
        2: begin e_scyc = 3'b100; e_dat = s_dat_i[95:64]; e_ack = s_ack_i[2]; end
        default: ;
      endcase
    end
    e_err   = m_err && !e_ack && e_gr;
    e_grant = (m_own == 1) ? 2'b01 : (m_own == 2) ? 2'b10 : 2'b00;
`ifdef WB_TIMEOUT_EN
    e_fire  = e_gstb && !e_ack && !m_err && (m_to + 1 == int'(TO));
`else
    e_fire  = 1'b0;
`endif
  end

  always @(posedge clk) begin
    if (rst) begin
      m_own  <= 0;
      m_last <= 1'b1;
      m_err  <= 1'b0;
      m_to   <= 0;
    end else begin
      if (e_gstb && !e_ack && !m_err && !e_fire) m_to <= m_to + 1;
      else m_to <= 0;
      m_err <= (e_gstb && e_reg == 3 && !m_err) || e_fire;
      if (m_own == 0) begin
        if (m0_cyc && m1_cyc) begin
          m_own  <= m_last ? 1 : 2;
          m_last <= !m_last;
        end else if (m0_cyc) begin
          m_own  <= 1;
          m_last <= 1'b0;
        end else if (m1_cyc) begin
          m_own  <= 2;
          m_last <= 1'b1;
        end
      end else if (!e_gcyc) begin
        m_own <= 0;
      end
    end
  end

  always @(negedge clk) begin
    if (en) begin
      chk("grant", 32'(grant_o), 32'(e_grant));
      chk("s_cyc", 32'(s_cyc_o), 32'(e_scyc));
      chk("s_stb", 32'(s_stb_o), 32'(e_gstb));
      chk("m0_ack", 32'(m0_ack_o), 32'(e_ack && !e_o));
      chk("m1_ack", 32'(m1_ack_o), 32'(e_ack && e_o));
      chk("m0_err", 32'(m0_err_o), 32'(e_err && !e_o));
      chk("m1_err", 32'(m1_err_o), 32'(e_err && e_o));
      chk("m0_dat", m0_dat_o, e_dat);
      chk("m1_dat", m1_dat_o, e_dat);
      if (e_gr) begin
        chk("s_adr", s_adr_o, e_adr);
        chk("s_dat", s_dat_o, e_o ? m1_dat : m0_dat);
        chk("s_sel", 32'(s_sel_o), 32'(e_o ? m1_sel : m0_sel));
        chk("s_we", 32'(s_we_o), 32'(e_o ? m1_we : m0_we));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_masters();
    m0_cyc = 0; m0_stb = 0; m0_we = 0;
    m1_cyc = 0; m1_stb = 0; m1_we = 0;
    s_ack_i = 3'b000;
  endtask

  logic [31:0] dec_adr [10];
  logic [2:0]  dec_cyc [10];
  bit          saw_err;

  initial begin
    dec_adr = '{32'h0000_0000, 32'h0001_FFFC, 32'h0002_0000,
                32'h1000_0000, 32'h2000_0000, 32'h1000_0004,
                32'h3000_0008, 32'h2FFF_FFFC, 32'h4000_0000,
                32'h4000_000C};
    dec_cyc = '{3'b001, 3'b001, 3'b000, 3'b001, 3'b001,
                3'b000, 3'b010, 3'b000, 3'b100, 3'b000};
    rst = 1;
    m0_adr = 0; m0_dat = 32'h1111_1111; m0_sel = 4'hF;
    m1_adr = 0; m1_dat = 32'h2222_2222; m1_sel = 4'hF;
    idle_masters();
    s_dat_i = {32'hC0C0_0002, 32'hB0B0_0001, 32'hA0A0_0000};
    tick();
    tick();
    en = 1'b1;
    chk("rst_grant", 32'(grant_o), 32'h0);
    chk("rst_scyc", 32'(s_cyc_o), 32'h0);
    chk("rst_stb", 32'(s_stb_o), 32'h0);
    chk("rst_err", 32'({m0_err_o, m1_err_o}), 32'h0);
    rst = 0;

    // m0 reads RAM, ack two cycles after grant
    m0_adr = 32'h0000_0010; m0_cyc = 1; m0_stb = 1;
    tick();
    chk("t1_grant", 32'(grant_o), 32'h1);
    chk("t1_scyc", 32'(s_cyc_o), 32'h1);
    tick();
    tick();
    s_ack_i = 3'b001;
    #1;
    chk("t1_ack", 32'(m0_ack_o), 32'h1);
    chk("t1_dat", m0_dat_o, 32'hA0A0_0000);
    chk("t1_m1ack", 32'(m1_ack_o), 32'h0);
    tick();
    idle_masters();
    tick();
    tick();

    // contention out of reset, then handover to m1
    rst = 1;
    tick();
    rst = 0;
    m0_adr = 32'h20; m1_adr = 32'h24;
    m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1;
    tick();
    chk("t2_first", 32'(grant_o), 32'h1);
    m0_cyc = 0; m0_stb = 0;
    tick();
    chk("t2_gap", 32'(grant_o), 32'h0);
    tick();
    chk("t2_m1", 32'(grant_o), 32'h2);

    // m1 writes GPIO2
    m1_adr = 32'h4000_0008; m1_dat = 32'hDEAD_BEEF;
    m1_sel = 4'b0110; m1_we = 1;
    #1;
    chk("t3_scyc", 32'(s_cyc_o), 32'h4);
    chk("t3_sdat", s_dat_o, 32'hDEAD_BEEF);
    chk("t3_sel", 32'(s_sel_o), 32'h6);
    chk("t3_we", 32'(s_we_o), 32'h1);
    s_ack_i = 3'b100;
    #1;
    chk("t3_ack", 32'(m1_ack_o), 32'h1);
    chk("t3_m0ack", 32'(m0_ack_o), 32'h0);
    s_ack_i = 3'b001;
    #1;
    chk("t3_wrongack", 32'(m1_ack_o), 32'h0);
    tick();
    idle_masters();
    m1_sel = 4'hF;
    tick();
    tick();

    // unmapped GPIO1 word 3
    m0_adr = 32'h3000_000C; m0_cyc = 1; m0_stb = 1;
    tick();
    chk("t4_scyc", 32'(s_cyc_o), 32'h0);
    chk("t4_err0", 32'(m0_err_o), 32'h0);
    tick();
    chk("t4_err1", 32'(m0_err_o), 32'h1);
    chk("t4_ack", 32'(m0_ack_o), 32'h0);
    tick();
    chk("t4_err2", 32'(m0_err_o), 32'h0);
    idle_masters();
    tick();
    tick();

    // decode boundaries while m0 holds the bus
    m0_adr = 32'h0; m0_cyc = 1; m0_stb = 1;
    tick();
    for (int i = 0; i < 10; i++) begin
      m0_adr = dec_adr[i];
      #1;
      chk($sformatf("dec_%h", dec_adr[i]), 32'(s_cyc_o), 32'(dec_cyc[i]));
      tick();
    end
    idle_masters();
    tick();
    tick();

    // RAM never acks
    m0_adr = 32'h0000_0100; m0_cyc = 1; m0_stb = 1;
    tick();
`ifdef WB_TIMEOUT_EN
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk($sformatf("to_%0d", k), 32'(m0_err_o), 32'(k == 8));
    end
`else
    saw_err = 0;
    for (int k = 0; k < 1000; k++) begin
      tick();
      if (m0_err_o) saw_err = 1;
    end
    chk("no_timeout", 32'(saw_err), 32'h0);
    chk("stalled", 32'(s_cyc_o), 32'h1);
`endif
    idle_masters();
    tick();
    tick();

    // reset during a GPIO1 transfer
    m1_adr = 32'h3000_0004; m1_cyc = 1; m1_stb = 1;
    tick();
    chk("t6_scyc", 32'(s_cyc_o), 32'h2);
    chk("t6_grant", 32'(grant_o), 32'h2);
    rst = 1;
    tick();
    chk("t6_rscyc", 32'(s_cyc_o), 32'h0);
    chk("t6_rgrant", 32'(grant_o), 32'h0);
    rst = 0;
    s_ack_i = 3'b010;
    #1;
    chk("t6_lateack", 32'(m1_ack_o), 32'h0);
    idle_masters();
    tick();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
